// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the push-button conditioner.
//   key_state_t  : debounce FSM state encoding
//   ms_to_cycles : converts a millisecond interval to clock cycles at
//                  elaboration time; never returns less than 1 so the
//                  terminal-count compares stay meaningful.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        int unsigned cyc;
        cyc = clk_hz / 1000 * ms;
        if (cyc == 0) begin
            cyc = 1;
        end
        return cyc;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff -- two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock
//   rst : synchronous active-high reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner -- debounces a raw push-button and produces press,
// release and long-press events.
//   clk          : sole clock, rising edge
//   rst          : synchronous active-high reset
//   key_in       : raw asynchronous button pin
//   key_flag     : one-cycle pulse on each accepted press
//   key_level    : debounced pressed state
//   release_flag : one-cycle pulse on each accepted release
//   long_flag    : one-cycle pulse once a press has been held LONG_MS
// Build option: define KEY_LONG_PRESS_EN to build the hold counter and
// long_flag; otherwise long_flag is tied low.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned LONG_MS         = 1000,
    parameter bit          KEY_ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_level,
    output logic release_flag,
    output logic long_flag
);

    localparam int unsigned DB_CYC = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
    localparam int CNT_W = $clog2(DB_CYC + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
    // Pin level that means "not pressed", so the synchronizer resets idle.
    localparam logic IDLE_LEVEL = KEY_ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic sync_q;
    logic p;

    sync_2ff #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (key_in),
        .q  (sync_q)
    );

    assign p = KEY_ACTIVE_HIGH ? sync_q : ~sync_q;

    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             key_flag_reg, key_flag_next;
    logic             key_level_reg, key_level_next;
    logic             release_flag_reg, release_flag_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            key_flag_reg     <= 1'b0;
            key_level_reg    <= 1'b0;
            release_flag_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            key_flag_reg     <= key_flag_next;
            key_level_reg    <= key_level_next;
            release_flag_reg <= release_flag_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        key_flag_next     = 1'b0;
        key_level_next    = key_level_reg;
        release_flag_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (p) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!p) begin
                    state_next = IDLE;
                end else if (cnt_reg == DB_LAST) begin
                    state_next     = PRESSED;
                    key_flag_next  = 1'b1;
                    key_level_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A short high here is contact bounce: go back to PRESSED
                // with the hold progress untouched.
                if (p) begin
                    state_next = PRESSED;
                end else if (cnt_reg == DB_LAST) begin
                    state_next        = IDLE;
                    release_flag_next = 1'b1;
                    key_level_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign key_flag     = key_flag_reg;
    assign key_level    = key_level_reg;
    assign release_flag = release_flag_reg;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_FREQ_HZ, LONG_MS);
    // Hold counting starts when the press is accepted, so the target is the
    // remainder after debounce. A target of 1 puts long_flag in the cycle
    // right after key_flag when LONG_CYC does not exceed DB_CYC.
    localparam int unsigned LONG_TGT = (LONG_CYC > DB_CYC) ? (LONG_CYC - DB_CYC) : 1;
    localparam int HOLD_W = $clog2(LONG_TGT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TGT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TGT - 1);

    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              long_fired_reg, long_fired_next;
    logic              long_flag_reg, long_flag_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg       <= '0;
            long_fired_reg <= 1'b0;
            long_flag_reg  <= 1'b0;
        end else begin
            hold_reg       <= hold_next;
            long_fired_reg <= long_fired_next;
            long_flag_reg  <= long_flag_next;
        end
    end

    always_comb begin
        hold_next       = hold_reg;
        long_fired_next = long_fired_reg;
        long_flag_next  = 1'b0;
        if (state_reg == PRESS_WAIT && state_next == PRESSED) begin
            // New press accepted: restart hold timing.
            hold_next       = '0;
            long_fired_next = 1'b0;
        end else if (state_reg == PRESSED) begin
            // Saturate at the target so a very long hold never re-fires.
            if (hold_reg != HOLD_MAX) begin
                hold_next = hold_reg + HOLD_W'(1);
            end
            if (hold_reg == HOLD_LAST && !long_fired_reg) begin
                long_flag_next  = 1'b1;
                long_fired_next = 1'b1;
            end
        end
    end

    assign long_flag = long_flag_reg;
`else
    assign long_flag = 1'b0;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_flag;
    logic key_level;
    logic release_flag;
    logic long_flag;

    int tests_run = 0;
    int tests_failed = 0;

    // Monitor state, relative to the edge at which clear_mon was called.
    int cyc;
    int kf_cnt, kf_first, kf_last;
    int lf_cnt, lf_first;
    int rf_cnt, rf_first;
    int lvl_rise, lvl_fall;
    int overlap_cnt = 0;
    logic prev_level;

    always #5 clk = ~clk;

    key_conditioner #(
        .CLK_FREQ_HZ(1000),
        .DEBOUNCE_MS(20),
        .LONG_MS(100),
        .KEY_ACTIVE_HIGH(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .key_flag(key_flag),
        .key_level(key_level),
        .release_flag(release_flag),
        .long_flag(long_flag)
    );

    task automatic clear_mon();
        cyc = 0;
        kf_cnt = 0; kf_first = -1; kf_last = -1;
        lf_cnt = 0; lf_first = -1;
        rf_cnt = 0; rf_first = -1;
        lvl_rise = -1; lvl_fall = -1;
        prev_level = key_level;
    endtask

    // Advance n cycles; sample 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (key_flag) begin
                kf_cnt++;
                if (kf_first < 0) kf_first = cyc;
                kf_last = cyc;
            end
            if (long_flag) begin
                lf_cnt++;
                if (lf_first < 0) lf_first = cyc;
            end
            if (release_flag) begin
                rf_cnt++;
                if (rf_first < 0) rf_first = cyc;
            end
            if ((int'(key_flag) + int'(long_flag) + int'(release_flag)) > 1) overlap_cnt++;
            if (key_level && !prev_level) lvl_rise = cyc;
            if (!key_level && prev_level) lvl_fall = cyc;
            prev_level = key_level;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (key_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_key_flag got %b want 0", key_flag); end
        tests_run++;
        if (key_level !== 1'b0) begin tests_failed++; $display("FAIL reset_key_level got %b want 0", key_level); end
        tests_run++;
        if (release_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_release_flag got %b want 0", release_flag); end
        tests_run++;
        if (long_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_long_flag got %b want 0", long_flag); end
        $display("[TB] reset: outputs kf=%b lvl=%b rf=%b lf=%b", key_flag, key_level, release_flag, long_flag);
    endtask

    task automatic test_clean_press();
        clear_mon();
        key_in = 1'b1;
        step(40);
        tests_run++;
        if (kf_first !== 23) begin tests_failed++; $display("FAIL clean_kf_cycle got %0d want 23", kf_first); end
        tests_run++;
        if (kf_cnt !== 1) begin tests_failed++; $display("FAIL clean_kf_count got %0d want 1", kf_cnt); end
        tests_run++;
        if (lvl_rise !== 23) begin tests_failed++; $display("FAIL clean_level_rise got %0d want 23", lvl_rise); end
        tests_run++;
        if (key_level !== 1'b1) begin tests_failed++; $display("FAIL clean_level_held got %b want 1", key_level); end
        $display("[TB] clean press: key_flag at %0d count %0d", kf_first, kf_cnt);
        clear_mon();
        key_in = 1'b0;
        step(30);
        tests_run++;
        if (rf_first !== 23) begin tests_failed++; $display("FAIL clean_rf_cycle got %0d want 23", rf_first); end
        tests_run++;
        if (lvl_fall !== 23) begin tests_failed++; $display("FAIL clean_level_fall got %0d want 23", lvl_fall); end
        tests_run++;
        if (kf_cnt !== 0) begin tests_failed++; $display("FAIL clean_release_kf got %0d want 0", kf_cnt); end
        $display("[TB] clean release: release_flag at %0d", rf_first);
    endtask

    task automatic test_bounce();
        clear_mon();
        key_in = 1'b1; step(10);
        key_in = 1'b0; step(3);
        key_in = 1'b1; step(37);
        // Final rise at cycle 13, accepted 23 cycles later.
        tests_run++;
        if (kf_first !== 36) begin tests_failed++; $display("FAIL bounce_kf_cycle got %0d want 36", kf_first); end
        tests_run++;
        if (kf_cnt !== 1) begin tests_failed++; $display("FAIL bounce_kf_count got %0d want 1", kf_cnt); end
        $display("[TB] press bounce: key_flag at %0d count %0d", kf_first, kf_cnt);
        key_in = 1'b0;
        step(30);
    endtask

    task automatic test_long_press();
        clear_mon();
        key_in = 1'b1;
        step(200);
        tests_run++;
        if (kf_first !== 23) begin tests_failed++; $display("FAIL long_kf_cycle got %0d want 23", kf_first); end
`ifdef KEY_LONG_PRESS_EN
        tests_run++;
        if (lf_cnt !== 1) begin tests_failed++; $display("FAIL long_lf_count got %0d want 1", lf_cnt); end
        tests_run++;
        if (lf_first !== 103) begin tests_failed++; $display("FAIL long_lf_cycle got %0d want 103", lf_first); end
`else
        tests_run++;
        if (lf_cnt !== 0) begin tests_failed++; $display("FAIL long_lf_disabled got %0d want 0", lf_cnt); end
`endif
        $display("[TB] long press: key_flag at %0d long_flag count %0d first %0d", kf_first, lf_cnt, lf_first);
        clear_mon();
        key_in = 1'b0;
        step(30);
        tests_run++;
        if (rf_first !== 23) begin tests_failed++; $display("FAIL long_rf_cycle got %0d want 23", rf_first); end
        tests_run++;
        if (lf_cnt !== 0) begin tests_failed++; $display("FAIL long_lf_after_release got %0d want 0", lf_cnt); end
        $display("[TB] long release: release_flag at %0d", rf_first);
    endtask

    task automatic test_release_bounce();
        clear_mon();
        key_in = 1'b1;
        step(30);
        clear_mon();
        key_in = 1'b0; step(5);
        key_in = 1'b1; step(2);
        key_in = 1'b0; step(40);
        // Final fall at cycle 7, release accepted 23 cycles later.
        tests_run++;
        if (rf_first !== 30) begin tests_failed++; $display("FAIL relbounce_rf_cycle got %0d want 30", rf_first); end
        tests_run++;
        if (rf_cnt !== 1) begin tests_failed++; $display("FAIL relbounce_rf_count got %0d want 1", rf_cnt); end
        tests_run++;
        if (kf_cnt !== 0) begin tests_failed++; $display("FAIL relbounce_kf_count got %0d want 0", kf_cnt); end
        tests_run++;
        if (lvl_fall !== 30) begin tests_failed++; $display("FAIL relbounce_level_fall got %0d want 30", lvl_fall); end
        $display("[TB] release bounce: release_flag at %0d count %0d", rf_first, rf_cnt);
    endtask

    task automatic test_reset_mid_hold();
        clear_mon();
        key_in = 1'b1;
        step(50);
        rst = 1'b1;
        step(5);
        tests_run++;
        if (key_level !== 1'b0) begin tests_failed++; $display("FAIL midrst_level_in_reset got %b want 0", key_level); end
        tests_run++;
        if (lvl_fall !== 51) begin tests_failed++; $display("FAIL midrst_level_fall got %0d want 51", lvl_fall); end
        rst = 1'b0;
        step(45);
        tests_run++;
        if (kf_cnt !== 2 || kf_last !== 78) begin
            tests_failed++;
            $display("FAIL midrst_new_press got count %0d last %0d want count 2 last 78", kf_cnt, kf_last);
        end
        tests_run++;
        if (rf_cnt !== 0) begin tests_failed++; $display("FAIL midrst_release got %0d want 0", rf_cnt); end
        $display("[TB] reset mid-hold: key_flag count %0d last %0d release count %0d", kf_cnt, kf_last, rf_cnt);
        key_in = 1'b0;
        step(30);
    endtask

    task automatic test_exclusive();
        tests_run++;
        if (overlap_cnt !== 0) begin tests_failed++; $display("FAIL flags_exclusive got %0d overlaps want 0", overlap_cnt); end
        $display("[TB] flag overlap cycles: %0d", overlap_cnt);
    endtask

    initial begin
        rst = 1'b1;
        key_in = 1'b0;
        clear_mon();
        step(3);
        test_reset();
        rst = 1'b0;
        step(5);
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_bounce();
        test_reset_mid_hold();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
